mem_arbiter: RTL and testbench

Single-port memory arbiter between the core's data port (load/store from the ALU/MEM boundary), the instruction-fetch port, and the VGA framebuffer reader. It serialises their accesses onto one synchronous RAM port and returns read data or a write acknowledge to the owning requester. It also drives the pipeline stall while a core-side access is outstanding. It sits between the PC/RAM/VGA blocks and the shared memory macro.

---
 rtl/mem_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the core data port, instruction fetch and VGA
// framebuffer reader onto one synchronous single-port RAM. Grants are issued
// only from IDLE. The completion comes LATENCY cycles after the grant. A VGA
// reader that keeps losing arbitration is promoted to top priority.
module mem_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned VGA_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,

    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic          v_gnt,
    output logic          v_rvalid,
    output logic [31:0]   v_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,

    output logic          o_stall
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned WAIT_W = 4;

    // BUSY lasts LATENCY-1 cycles; the counter is loaded with one less than that.
    localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(VGA_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_F    = 2'd2,
        OWN_V    = 2'd3
    } owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             win_c;
    logic               wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  vga_wait_q, vga_wait_d;
    logic               d_pend_q, d_pend_d;
    logic               f_pend_q, f_pend_d;

    // Arbitration winner; only IDLE outside reset can produce one.
    always_comb begin
        win_c = OWN_NONE;
        if (!rst && state_q == S_IDLE) begin
            if (v_req && vga_wait_q >= WAIT_MAX) begin
                win_c = OWN_V;
            end else if (d_req) begin
                win_c = OWN_D;
            end else if (f_req) begin
                win_c = OWN_F;
            end else if (v_req) begin
                win_c = OWN_V;
            end
        end
    end

    // State register: FSM state, current owner, write flag, latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> BUSY/RESP on a grant, BUSY counts down, RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_c != OWN_NONE) begin
                    owner_d = win_c;
                    wr_d    = (win_c == OWN_D) && d_we;
                    if (LATENCY > 1) begin
                        state_d = S_BUSY;
                        cnt_d   = BUSY_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                wr_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Outputs: grant and RAM strobe in the IDLE grant cycle, completion in RESP.
    always_comb begin
        d_gnt     = 1'b0;
        f_gnt     = 1'b0;
        v_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        f_rvalid  = 1'b0;
        v_rvalid  = 1'b0;
        d_rdata   = '0;
        f_rdata   = '0;
        v_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (win_c)
            OWN_D: begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end
            OWN_F: begin
                f_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = f_addr;
            end
            OWN_V: begin
                v_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = v_addr;
            end
            default: ;
        endcase
        if (!rst && state_q == S_RESP) begin
            case (owner_q)
                OWN_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = wr_q ? 32'h0 : mem_rdata;
                end
                OWN_F: begin
                    f_rvalid = 1'b1;
                    f_rdata  = mem_rdata;
                end
                OWN_V: begin
                    v_rvalid = 1'b1;
                    v_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // VGA starvation counter and core-side outstanding flags.
    always_comb begin
        vga_wait_d = vga_wait_q;
        if (!v_req || v_gnt) begin
            vga_wait_d = '0;
        end else if (vga_wait_q < WAIT_MAX) begin
            vga_wait_d = vga_wait_q + 1'b1;
        end

        d_pend_d = d_pend_q;
        if (d_gnt) begin
            d_pend_d = 1'b1;
        end else if (d_rvalid) begin
            d_pend_d = 1'b0;
        end

        f_pend_d = f_pend_q;
        if (f_gnt) begin
            f_pend_d = 1'b1;
        end else if (f_rvalid) begin
            f_pend_d = 1'b0;
        end
    end

    // Registers for the starvation counter and outstanding flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_wait_q <= '0;
            d_pend_q   <= 1'b0;
            f_pend_q   <= 1'b0;
        end else begin
            vga_wait_q <= vga_wait_d;
            d_pend_q   <= d_pend_d;
            f_pend_q   <= f_pend_d;
        end
    end

    // Core stalls while a data or fetch access is requested or in flight.
    assign o_stall = !rst && (((d_req || d_pend_q) && !d_rvalid) ||
                              ((f_req || f_pend_q) && !f_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Four instances with different LATENCY and
// VGA_MAX_WAIT share the input stimulus; each vector names the instance whose
// outputs it checks. Each instance has its own behavioural RAM.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        d_req, d_we, f_req, v_req;
    logic [15:0] d_addr, f_addr, v_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic [3:0]  d_gnt_w, d_rvalid_w, f_gnt_w, f_rvalid_w, v_gnt_w, v_rvalid_w;
    logic [3:0]  mem_en_w, mem_we_w, stall_w;
    logic [31:0] d_rdata_w [4];
    logic [31:0] f_rdata_w [4];
    logic [31:0] v_rdata_w [4];
    logic [31:0] mem_wdata_w [4];
    logic [31:0] mem_rdata_w [4];
    logic [15:0] mem_addr_w [4];
    logic [3:0]  mem_wstrb_w [4];

    typedef struct {
        logic [2:0]  gnt;   // {d,f,v}
        logic [2:0]  rv;    // {d,f,v}
        logic        stall;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] drd;
        logic [31:0] frd;
        logic [31:0] vrd;
    } exp_t;

    typedef struct {
        int          inst;
        logic        rst;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        logic        f_req;
        logic [15:0] f_addr;
        logic        v_req;
        logic [15:0] v_addr;
        exp_t        e;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cmp  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance 0: LAT1/W8, 1: LAT2/W8, 2: LAT1/W4, 3: LAT3/W8
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 2 : (g == 3) ? 3 : 1;
        localparam int VMW = (g == 2) ? 4 : 8;

        logic [31:0] ram  [256];
        logic [31:0] pipe [LAT];

        mem_arbiter #(.AW(16), .LATENCY(LAT), .VGA_MAX_WAIT(VMW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_wstrb   (d_wstrb),
            .d_gnt     (d_gnt_w[g]),
            .d_rvalid  (d_rvalid_w[g]),
            .d_rdata   (d_rdata_w[g]),
            .f_req     (f_req),
            .f_addr    (f_addr),
            .f_gnt     (f_gnt_w[g]),
            .f_rvalid  (f_rvalid_w[g]),
            .f_rdata   (f_rdata_w[g]),
            .v_req     (v_req),
            .v_addr    (v_addr),
            .v_gnt     (v_gnt_w[g]),
            .v_rvalid  (v_rvalid_w[g]),
            .v_rdata   (v_rdata_w[g]),
            .mem_en    (mem_en_w[g]),
            .mem_we    (mem_we_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .mem_wstrb (mem_wstrb_w[g]),
            .mem_rdata (mem_rdata_w[g]),
            .o_stall   (stall_w[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
        end

        // RAM model: byte-strobed write, read data LAT cycles after mem_en,
        // poison value on cycles without an access.
        always @(posedge clk) begin
            if (mem_en_w[g] && mem_we_w[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb_w[g][b])
                        ram[mem_addr_w[g][7:0]][8*b +: 8] <= mem_wdata_w[g][8*b +: 8];
                end
            end
            pipe[0] <= mem_en_w[g] ? ram[mem_addr_w[g][7:0]] : 32'hBAD0_0BAD;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        assign mem_rdata_w[g] = pipe[LAT-1];
    end

    function automatic exp_t ex(logic [2:0] gnt, logic [2:0] rv, logic stall,
                                logic en, logic we, logic [15:0] addr,
                                logic [31:0] wdata, logic [3:0] wstrb,
                                logic [31:0] drd, logic [31:0] frd, logic [31:0] vrd);
        exp_t e;
        e.gnt = gnt; e.rv = rv; e.stall = stall; e.en = en; e.we = we;
        e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        e.drd = drd; e.frd = frd; e.vrd = vrd;
        return e;
    endfunction

    function automatic vec_t vin(int inst, logic r, logic dq, logic dw,
                                 logic [15:0] da, logic [31:0] dd, logic [3:0] ds,
                                 logic fq, logic [15:0] fa, logic vq, logic [15:0] va,
                                 exp_t e);
        vec_t v;
        v.inst = inst; v.rst = r; v.d_req = dq; v.d_we = dw; v.d_addr = da;
        v.d_wdata = dd; v.d_wstrb = ds; v.f_req = fq; v.f_addr = fa;
        v.v_req = vq; v.v_addr = va; v.e = e;
        return v;
    endfunction

    task automatic cmp(string tag, string what, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %h want %h", tag, what, act, exp);
        end
    endtask

    task automatic check(string tag, int k, exp_t e);
        n_vec++;
        cmp(tag, "gnt",       32'({d_gnt_w[k], f_gnt_w[k], v_gnt_w[k]}), 32'(e.gnt));
        cmp(tag, "rvalid",    32'({d_rvalid_w[k], f_rvalid_w[k], v_rvalid_w[k]}), 32'(e.rv));
        cmp(tag, "o_stall",   32'(stall_w[k]), 32'(e.stall));
        cmp(tag, "mem_en",    32'(mem_en_w[k]), 32'(e.en));
        cmp(tag, "mem_we",    32'(mem_we_w[k]), 32'(e.we));
        cmp(tag, "mem_addr",  32'(mem_addr_w[k]), 32'(e.addr));
        cmp(tag, "mem_wdata", mem_wdata_w[k], e.wdata);
        cmp(tag, "mem_wstrb", 32'(mem_wstrb_w[k]), 32'(e.wstrb));
        cmp(tag, "d_rdata",   d_rdata_w[k], e.drd);
        cmp(tag, "f_rdata",   f_rdata_w[k], e.frd);
        cmp(tag, "v_rdata",   v_rdata_w[k], e.vrd);
    endtask

    // Drive one cycle of inputs just after the edge, check mid-cycle, then advance.
    task automatic apply(string tag, vec_t v);
        rst     = v.rst;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        d_wstrb = v.d_wstrb;
        f_req   = v.f_req;
        f_addr  = v.f_addr;
        v_req   = v.v_req;
        v_addr  = v.v_addr;
        #4;
        check(tag, v.inst, v.e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        exp_t z;
        z = ex(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);

        rst = 1'b1; d_req = 1'b0; d_we = 1'b0; f_req = 1'b0; v_req = 1'b0;
        d_addr = '0; f_addr = '0; v_addr = '0; d_wdata = '0; d_wstrb = '0;
        @(posedge clk);
        #1;

        // Instance 0 (LATENCY=1): reset, data write, data read, fetch read
        tbl.push_back(vin(0, 1, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(0, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(0, 0, 1,1,16'h0010,32'hDEADBEEF,4'hF, 0,16'h0, 0,16'h0,
                          ex(3'b100,3'b000,1,1,1,16'h0010,32'hDEADBEEF,4'hF,0,0,0)));
        tbl.push_back(vin(0, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b100,0,0,0,16'h0,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(0, 0, 1,0,16'h0010,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b100,3'b000,1,1,0,16'h0010,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(0, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b100,0,0,0,16'h0,32'h0,4'h0,32'hDEADBEEF,0,0)));
        tbl.push_back(vin(0, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0010, 0,16'h0,
                          ex(3'b010,3'b000,1,1,0,16'h0010,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(0, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b010,0,0,0,16'h0,32'h0,4'h0,0,32'hDEADBEEF,0)));

        // Instance 1 (LATENCY=2): all three requests together, order d, f, v
        tbl.push_back(vin(1, 1, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(1, 0, 1,0,16'h0020,32'h0,4'h0, 1,16'h0021, 1,16'h0022,
                          ex(3'b100,3'b000,1,1,0,16'h0020,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0021, 1,16'h0022,
                          ex(3'b000,3'b000,1,0,0,16'h0,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0021, 1,16'h0022,
                          ex(3'b000,3'b100,1,0,0,16'h0,32'h0,4'h0,32'h1000_0020,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0021, 1,16'h0022,
                          ex(3'b010,3'b000,1,1,0,16'h0021,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 1,16'h0022,
                          ex(3'b000,3'b000,1,0,0,16'h0,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 1,16'h0022,
                          ex(3'b000,3'b010,0,0,0,16'h0,32'h0,4'h0,0,32'h1000_0021,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 1,16'h0022,
                          ex(3'b001,3'b000,0,1,0,16'h0022,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(1, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b001,0,0,0,16'h0,32'h0,4'h0,0,0,32'h1000_0022)));

        // Instance 2 (LATENCY=1, VGA_MAX_WAIT=4): VGA forced past a held d_req
        tbl.push_back(vin(2, 1, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        tbl.push_back(vin(2, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(vin(2, 0, 1,0,16'h0030,32'h0,4'h0, 0,16'h0, 1,16'h0031,
                              ex(3'b100,3'b000,1,1,0,16'h0030,32'h0,4'h0,0,0,0)));
            tbl.push_back(vin(2, 0, 1,0,16'h0030,32'h0,4'h0, 0,16'h0, 1,16'h0031,
                              ex(3'b000,3'b100,0,0,0,16'h0,32'h0,4'h0,32'h1000_0030,0,0)));
        end
        tbl.push_back(vin(2, 0, 1,0,16'h0030,32'h0,4'h0, 0,16'h0, 1,16'h0031,
                          ex(3'b001,3'b000,1,1,0,16'h0031,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(2, 0, 1,0,16'h0030,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b001,1,0,0,16'h0,32'h0,4'h0,0,0,32'h1000_0031)));
        tbl.push_back(vin(2, 0, 1,0,16'h0030,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b100,3'b000,1,1,0,16'h0030,32'h0,4'h0,0,0,0)));
        tbl.push_back(vin(2, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                          ex(3'b000,3'b100,0,0,0,16'h0,32'h0,4'h0,32'h1000_0030,0,0)));

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Instance 3 (LATENCY=3): reset with requests present masks everything
        apply("rst_req", vin(3, 1, 1,0,16'h0040,32'h0,4'h0, 1,16'h0050, 1,16'h0060, z));
        apply("rst_idle", vin(3, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));

        // Abort: reset the cycle after d_gnt; late RAM data must be ignored
        apply("abort_gnt", vin(3, 0, 1,0,16'h0040,32'h0,4'h0, 0,16'h0, 0,16'h0,
                               ex(3'b100,3'b000,1,1,0,16'h0040,32'h0,4'h0,0,0,0)));
        apply("abort_rst", vin(3, 1, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));
        for (int k = 0; k < 6; k++)
            apply($sformatf("abort_after%0d", k),
                  vin(3, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));

        // Dropped fetch: raised during BUSY, withdrawn in the RESP cycle
        apply("drop_dgnt", vin(3, 0, 1,0,16'h0041,32'h0,4'h0, 0,16'h0, 0,16'h0,
                               ex(3'b100,3'b000,1,1,0,16'h0041,32'h0,4'h0,0,0,0)));
        apply("drop_busy1", vin(3, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0050, 0,16'h0,
                                ex(3'b000,3'b000,1,0,0,16'h0,32'h0,4'h0,0,0,0)));
        apply("drop_busy2", vin(3, 0, 0,0,16'h0,32'h0,4'h0, 1,16'h0050, 0,16'h0,
                                ex(3'b000,3'b000,1,0,0,16'h0,32'h0,4'h0,0,0,0)));
        apply("drop_resp", vin(3, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0,
                               ex(3'b000,3'b100,0,0,0,16'h0,32'h0,4'h0,32'h1000_0041,0,0)));
        for (int k = 0; k < 4; k++)
            apply($sformatf("drop_after%0d", k),
                  vin(3, 0, 0,0,16'h0,32'h0,4'h0, 0,16'h0, 0,16'h0, z));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
